// File: rtl/cpu_trace_pkg.sv
// Shared encodings for the CPU execution-trace unit.
// CPU_TRACE_WB_VALUE_EN selects whether trace entries also keep the write-back value.
package cpu_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HALT    = 2'd2,
    ST_FROZEN  = 2'd3
  } state_e;

`ifdef CPU_TRACE_WB_VALUE_EN
  localparam bit WB_VALUE_EN = 1'b1;
`else
  localparam bit WB_VALUE_EN = 1'b0;
`endif

  // Stored entry layout is {pc, value} or {pc} depending on the build.
  function automatic int unsigned entry_width(input int unsigned addr_w, input int unsigned data_w);
    return WB_VALUE_EN ? addr_w + data_w : addr_w;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Trace storage: circular buffer with registered head, count and optional overwrite-oldest.
module trace_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  input  logic                         overwrite_en,
  output logic                         full_c,
  output logic                         rd_valid,
  output logic [WIDTH-1:0]             rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_ptr_nxt;
  logic [CW-1:0]    count_nxt;
  logic [WIDTH-1:0] head_nxt;
  logic             pop_ok;
  logic             over;
  logic             wr_en;

  assign full_c = (count == CW'(DEPTH));
  assign pop_ok = pop && rd_valid && !flush;
  // Overwrite only when full with no pop to make room.
  assign over   = push && full_c && !pop_ok && overwrite_en;
  assign wr_en  = push && (!full_c || pop_ok || overwrite_en);

  // Next head is forwarded from wdata when the write lands on the new read slot.
  always_comb begin
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    if (pop_ok || over) rd_ptr_nxt = rd_ptr + PW'(1);
    if (wr_en && !pop_ok && !over) count_nxt = count + CW'(1);
    else if (pop_ok && !wr_en)     count_nxt = count - CW'(1);
    head_nxt = (wr_en && (wr_ptr == rd_ptr_nxt)) ? wdata : mem[rd_ptr_nxt];
  end

  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr   <= rd_ptr_nxt;
      count    <= count_nxt;
      rd_valid <= (count_nxt != '0);
      rd_data  <= (count_nxt != '0) ? head_nxt : '0;
      if (over) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/cpu_trace_buffer.sv
// Execution-trace unit snooping the cpu debug bus: capture FSM, PC breakpoint, trace FIFO.
// CPU_TRACE_WB_VALUE_EN adds write-back value storage; otherwise rd_value is tied to 0.
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int unsigned I_ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned STAGE_COUNT  = 4,
  parameter int unsigned WB_STAGE     = STAGE_COUNT - 1,
  parameter int unsigned DEPTH        = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        arm,
  input  logic                        mode,
  input  logic [STAGE_COUNT-1:0]      debug_pipeline_stage,
  input  logic [I_ADDR_WIDTH-1:0]     debug_program_counter,
  input  logic [DATA_WIDTH-1:0]       debug_writeback_value,
  input  logic                        bp_en,
  input  logic [I_ADDR_WIDTH-1:0]     bp_addr,
  input  logic                        resume,
  output logic                        cpu_halt,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [I_ADDR_WIDTH-1:0]     rd_pc,
  output logic [DATA_WIDTH-1:0]       rd_value,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  output logic                        overflow,
  output logic [1:0]                  state
);

  localparam int unsigned EW = entry_width(I_ADDR_WIDTH, DATA_WIDTH);

  logic [1:0]    rst_sync;
  logic          rst_n;
  state_e        state_q;
  logic          strobe_c;
  logic          bp_hit_c;
  logic          push_c;
  logic          drop_c;
  logic          fifo_full_c;
  logic [EW-1:0] wdata_c;
  logic [EW-1:0] head;
  logic          unused_bus;

  // Reset asserts immediately, releases two clocks later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign strobe_c = (state_q == ST_CAPTURE) && debug_pipeline_stage[WB_STAGE];
  assign bp_hit_c = bp_en && (debug_program_counter == bp_addr);
  assign push_c   = strobe_c && !arm;
  assign drop_c   = push_c && fifo_full_c && !(rd_valid && rd_ready) && !mode;

`ifdef CPU_TRACE_WB_VALUE_EN
  assign wdata_c    = {debug_program_counter, debug_writeback_value};
  assign rd_pc      = head[EW-1 -: I_ADDR_WIDTH];
  assign rd_value   = head[DATA_WIDTH-1:0];
  assign unused_bus = ^debug_pipeline_stage;
`else
  assign wdata_c    = debug_program_counter;
  assign rd_pc      = head;
  assign rd_value   = '0;
  assign unused_bus = ^{debug_pipeline_stage, debug_writeback_value};
`endif

  // Capture control; a drop on full takes precedence over a breakpoint hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cpu_halt <= 1'b0;
    end else if (arm) begin
      state_q  <= ST_CAPTURE;
      cpu_halt <= 1'b0;
    end else begin
      case (state_q)
        ST_CAPTURE: begin
          if (drop_c) begin
            state_q <= ST_FROZEN;
          end else if (strobe_c && bp_hit_c) begin
            state_q  <= ST_HALT;
            cpu_halt <= 1'b1;
          end
        end
        ST_HALT: begin
          if (resume) begin
            state_q  <= ST_CAPTURE;
            cpu_halt <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign state = state_q;

  trace_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (arm),
    .push         (push_c),
    .wdata        (wdata_c),
    .pop          (rd_ready),
    .overwrite_en (mode),
    .full_c       (fifo_full_c),
    .rd_valid     (rd_valid),
    .rd_data      (head),
    .count        (count),
    .overflow     (overflow)
  );

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed scoreboard bench for cpu_trace_buffer (default parameters).
module tb_cpu_trace_buffer;

  localparam int DEPTH = 16;
  localparam int S_IDLE = 0, S_CAPTURE = 1, S_HALT = 2, S_FROZEN = 3;

  typedef struct {
    logic [9:0] pc;
    logic [7:0] val;
  } ent_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       arm = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] debug_pipeline_stage = 4'b0001;
  logic [9:0] debug_program_counter = '0;
  logic [7:0] debug_writeback_value = '0;
  logic       bp_en = 1'b0;
  logic [9:0] bp_addr = '0;
  logic       resume = 1'b0;
  logic       cpu_halt;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic [9:0] rd_pc;
  logic [7:0] rd_value;
  logic [4:0] count;
  logic       overflow;
  logic [1:0] state;

  int   n_cmp = 0;
  int   n_err = 0;
  ent_t m_q[$];
  int   m_state = S_IDLE;
  bit   m_ovf = 1'b0;

  cpu_trace_buffer dut (
    .clk                   (clk),
    .reset                 (reset),
    .arm                   (arm),
    .mode                  (mode),
    .debug_pipeline_stage  (debug_pipeline_stage),
    .debug_program_counter (debug_program_counter),
    .debug_writeback_value (debug_writeback_value),
    .bp_en                 (bp_en),
    .bp_addr               (bp_addr),
    .resume                (resume),
    .cpu_halt              (cpu_halt),
    .rd_valid              (rd_valid),
    .rd_ready              (rd_ready),
    .rd_pc                 (rd_pc),
    .rd_value              (rd_value),
    .count                 (count),
    .overflow              (overflow),
    .state                 (state)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_val(input logic [7:0] v);
`ifdef CPU_TRACE_WB_VALUE_EN
    return v;
`else
    return (v & 8'h00);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("state", 32'(state), 32'(m_state));
    check("count", 32'(count), 32'(m_q.size()));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("cpu_halt", 32'(cpu_halt), 32'(m_state == S_HALT));
    check("rd_valid", 32'(rd_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      check("head_pc", 32'(rd_pc), 32'(m_q[0].pc));
      check("head_value", 32'(rd_value), 32'(exp_val(m_q[0].val)));
    end
  endtask

  // One clock: drive inputs, update the model, clock, then compare.
  task automatic step(input bit wb, input logic [9:0] pc, input logic [7:0] val, input bit rdy);
    ent_t e;
    bit   full;
    bit   popped;
    debug_pipeline_stage  = wb ? 4'b1000 : 4'b0010;
    debug_program_counter = pc;
    debug_writeback_value = val;
    rd_ready              = rdy;
    full   = (m_q.size() == DEPTH);
    popped = rdy && (m_q.size() != 0) && !arm;
    if (arm) begin
      m_q.delete();
      m_ovf   = 1'b0;
      m_state = S_CAPTURE;
    end else begin
      if (popped) begin
        check("pop_pc", 32'(rd_pc), 32'(m_q[0].pc));
        check("pop_value", 32'(rd_value), 32'(exp_val(m_q[0].val)));
        void'(m_q.pop_front());
      end
      if (m_state == S_CAPTURE && wb) begin
        if (full && !popped && !mode) begin
          m_state = S_FROZEN;
        end else begin
          if (full && !popped) begin
            void'(m_q.pop_front());
            m_ovf = 1'b1;
          end
          e.pc  = pc;
          e.val = val;
          m_q.push_back(e);
          if (bp_en && pc == bp_addr) m_state = S_HALT;
        end
      end else if (m_state == S_HALT && resume) begin
        m_state = S_CAPTURE;
      end
    end
    @(posedge clk);
    #1;
    arm    = 1'b0;
    resume = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 10'h000, 8'h00, rdy);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all();
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    idle(3, 1'b0);

    // Four strobes drained in order
    arm = 1'b1;
    idle(1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 10'h010 + 10'(i), 8'hA0 + 8'(i), 1'b1);
    idle(4, 1'b1);
    check("drain_count", 32'(count), 32'd0);

    // Mode 0: seventeenth strobe is dropped and capture freezes
    mode = 1'b0;
    arm  = 1'b1;
    idle(1, 1'b0);
    for (int i = 0; i < 17; i++) step(1'b1, 10'h100 + 10'(i), 8'(i), 1'b0);
    check("m0_count", 32'(count), 32'd16);
    check("m0_state", 32'(state), 32'(S_FROZEN));
    check("m0_head", 32'(rd_pc), 32'h100);
    idle(17, 1'b1);

    // Mode 1: twenty strobes overwrite the four oldest
    mode = 1'b1;
    arm  = 1'b1;
    idle(1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 10'(i), 8'h40 + 8'(i), 1'b0);
    check("m1_overflow", 32'(overflow), 32'd1);
    check("m1_count", 32'(count), 32'd16);
    check("m1_head", 32'(rd_pc), 32'd4);

    // Arm with five stored entries and a same-cycle strobe
    idle(11, 1'b1);
    check("pre_arm_count", 32'(count), 32'd5);
    arm = 1'b1;
    step(1'b1, 10'h3FF, 8'hEE, 1'b0);
    check("arm_count", 32'(count), 32'd0);
    check("arm_overflow", 32'(overflow), 32'd0);
    check("arm_state", 32'(state), 32'(S_CAPTURE));

    // Full buffer, simultaneous strobe and pop: no overwrite
    for (int i = 0; i < 16; i++) step(1'b1, 10'h300 + 10'(i), 8'h80 + 8'(i), 1'b0);
    step(1'b1, 10'h310, 8'h90, 1'b1);
    check("pp_count", 32'(count), 32'd16);
    check("pp_overflow", 32'(overflow), 32'd0);
    idle(16, 1'b1);

    // Breakpoint halts; later strobes ignored; resume continues capture
    mode    = 1'b0;
    bp_en   = 1'b1;
    bp_addr = 10'h025;
    arm     = 1'b1;
    idle(1, 1'b0);
    for (int i = 3; i < 8; i++) step(1'b1, 10'h020 + 10'(i), 8'hB0 + 8'(i), 1'b0);
    check("bp_halt", 32'(cpu_halt), 32'd1);
    check("bp_count", 32'(count), 32'd3);
    resume = 1'b1;
    idle(1, 1'b0);
    check("resume_halt", 32'(cpu_halt), 32'd0);
    step(1'b1, 10'h028, 8'hB8, 1'b0);
    check("resume_count", 32'(count), 32'd4);
    idle(5, 1'b1);

    // Breakpoint hit while full in mode 0 freezes instead of halting
    bp_addr = 10'h210;
    arm     = 1'b1;
    idle(1, 1'b0);
    for (int i = 0; i < 17; i++) step(1'b1, 10'h200 + 10'(i), 8'(i), 1'b0);
    check("bpfull_state", 32'(state), 32'(S_FROZEN));
    check("bpfull_halt", 32'(cpu_halt), 32'd0);
    bp_en = 1'b0;

    // Reset mid-capture clears outputs without a clock edge
    arm = 1'b1;
    idle(1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 10'h050 + 10'(i), 8'hC0 + 8'(i), 1'b0);
    #2 reset = 1'b0;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_pc", 32'(rd_pc), 32'd0);
    check("rst_state", 32'(state), 32'(S_IDLE));
    check("rst_halt", 32'(cpu_halt), 32'd0);
    m_q.delete();
    m_ovf   = 1'b0;
    m_state = S_IDLE;
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    idle(3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
